// File: rtl/mem_stage_unit.sv
// Memory stage: consumes EX/MEM, runs a req/ack data-memory access and drives
// registered MEM/WB fields, stalling upstream while an access is outstanding.
module mem_stage_unit #(
    parameter logic [4:0] LOAD_OP  = 5'd10,
    parameter logic [4:0] STORE_OP = 5'd11,
    parameter int         TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  op_code,
    input  logic [8:0]  rd,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_valid,
    output logic [4:0]  wb_op_code,
    output logic [8:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_reg_write,
    output logic        misalign_err,
    output logic        timeout_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    logic [0:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [4:0]       op_reg;
    logic [8:0]       rd_reg;

    logic is_mem;
    logic aligned;

    assign is_mem  = (op_code == LOAD_OP) || (op_code == STORE_OP);
    assign aligned = (alu_result[1:0] == 2'b00);
    // Stall drops on the ack cycle so upstream advances on the completing edge.
    assign stall = ((state_reg == IDLE) && in_valid && is_mem && aligned) ||
                   ((state_reg == WAIT) && !mem_ack);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            op_reg       <= '0;
            rd_reg       <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            wb_valid     <= 1'b0;
            wb_op_code   <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            misalign_err <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mem && aligned) begin
                            state_reg <= WAIT;
                            mem_req   <= 1'b1;
                            mem_we    <= (op_code == STORE_OP);
                            mem_addr  <= alu_result;
                            mem_wdata <= store_data;
                            op_reg    <= op_code;
                            rd_reg    <= rd;
                            cnt_reg   <= '0;
                        end else begin
                            // Non-memory op, or misaligned access dropped without a request.
                            wb_valid     <= 1'b1;
                            wb_op_code   <= op_code;
                            wb_rd        <= rd;
                            wb_data      <= alu_result;
                            wb_reg_write <= !is_mem;
                            misalign_err <= is_mem;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state_reg    <= IDLE;
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_op_code   <= op_reg;
                        wb_rd        <= rd_reg;
                        wb_data      <= mem_we ? mem_addr : mem_rdata;
                        wb_reg_write <= !mem_we;
                    end else if (cnt_reg == CNT_LIMIT) begin
                        state_reg    <= IDLE;
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_op_code   <= op_reg;
                        wb_rd        <= rd_reg;
                        wb_data      <= mem_addr;
                        wb_reg_write <= 1'b0;
                        timeout_err  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_unit.sv
// Directed bench for mem_stage_unit: hand-computed vectors checked with immediate assertions.
module tb_mem_stage_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [4:0]  op_code;
    logic [8:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic [4:0]  wb_op_code;
    logic [8:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_reg_write;
    logic        misalign_err;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int req_cycles;

    mem_stage_unit #(.LOAD_OP(5'd10), .STORE_OP(5'd11), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .op_code(op_code), .rd(rd),
        .alu_result(alu_result), .store_data(store_data), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .wb_valid(wb_valid),
        .wb_op_code(wb_op_code), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_reg_write(wb_reg_write), .misalign_err(misalign_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic v, input logic [4:0] op, input logic [8:0] r,
                           input logic [31:0] a, input logic [31:0] sd);
        in_valid   = v;
        op_code    = op;
        rd         = r;
        alu_result = a;
        store_data = sd;
    endtask

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_mem_req", {31'b0, mem_req}, 32'd0);
        check("reset_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("reset_wb_data", wb_data, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_stall", {31'b0, stall}, 32'd0);
        $display("txn reset done");

        // Non-memory ops back to back
        present(1'b1, 5'd3, 9'd7, 32'h1234, 32'h0);
        #1 check("alu_stall", {31'b0, stall}, 32'd0);
        tick();
        check("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("alu_wb_data", wb_data, 32'h1234);
        check("alu_wb_rd", {23'b0, wb_rd}, 32'd7);
        check("alu_wb_op", {27'b0, wb_op_code}, 32'd3);
        check("alu_wb_we", {31'b0, wb_reg_write}, 32'd1);
        present(1'b1, 5'd4, 9'd8, 32'h55, 32'h0);
        tick();
        check("alu2_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("alu2_wb_data", wb_data, 32'h55);
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        tick();
        check("bubble_wb_valid", {31'b0, wb_valid}, 32'd0);
        check("bubble_wb_hold", wb_data, 32'h55);
        $display("txn alu ops done");

        // Load, ack on third WAIT cycle; instruction held upstream during WAIT
        present(1'b1, 5'd10, 9'd5, 32'h100, 32'h0);
        #1 check("ld_accept_stall", {31'b0, stall}, 32'd1);
        tick();
        check("ld_mem_req", {31'b0, mem_req}, 32'd1);
        check("ld_mem_we", {31'b0, mem_we}, 32'd0);
        check("ld_mem_addr", mem_addr, 32'h100);
        tick();
        check("ld_wait_stall", {31'b0, stall}, 32'd1);
        check("ld_wait_req", {31'b0, mem_req}, 32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1 check("ld_ack_stall", {31'b0, stall}, 32'd0);
        tick();
        mem_ack = 1'b0;
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        check("ld_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("ld_wb_data", wb_data, 32'hDEADBEEF);
        check("ld_wb_we", {31'b0, wb_reg_write}, 32'd1);
        check("ld_wb_rd", {23'b0, wb_rd}, 32'd5);
        check("ld_req_drop", {31'b0, mem_req}, 32'd0);
        tick();
        check("ld_wb_pulse", {31'b0, wb_valid}, 32'd0);
        $display("txn load done data=%h", wb_data);

        // Store with immediate ack
        present(1'b1, 5'd11, 9'd6, 32'h40, 32'hCAFE);
        tick();
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        check("st_mem_we", {31'b0, mem_we}, 32'd1);
        check("st_mem_wdata", mem_wdata, 32'hCAFE);
        check("st_wb_early", {31'b0, wb_valid}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("st_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("st_wb_we", {31'b0, wb_reg_write}, 32'd0);
        check("st_wb_data", wb_data, 32'h40);
        $display("txn store done");

        // Misaligned load
        present(1'b1, 5'd10, 9'd2, 32'h102, 32'h0);
        #1 check("mis_stall", {31'b0, stall}, 32'd0);
        tick();
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        check("mis_no_req", {31'b0, mem_req}, 32'd0);
        check("mis_err", {31'b0, misalign_err}, 32'd1);
        check("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("mis_wb_we", {31'b0, wb_reg_write}, 32'd0);
        check("mis_wb_data", wb_data, 32'h102);
        tick();
        check("mis_err_pulse", {31'b0, misalign_err}, 32'd0);
        $display("txn misaligned done");

        // Stray ack while idle
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_ignored", {31'b0, wb_valid}, 32'd0);
        $display("txn idle ack done");

        // Load with no ack: request lasts TIMEOUT cycles
        present(1'b1, 5'd10, 9'd9, 32'h200, 32'h0);
        tick();
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        req_cycles = 0;
        for (int i = 0; i < 40 && mem_req; i++) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", req_cycles, 32'd16);
        check("to_err", {31'b0, timeout_err}, 32'd1);
        check("to_wb_valid", {31'b0, wb_valid}, 32'd1);
        check("to_wb_we", {31'b0, wb_reg_write}, 32'd0);
        present(1'b1, 5'd3, 9'd1, 32'h77, 32'h0);
        tick();
        check("to_err_pulse", {31'b0, timeout_err}, 32'd0);
        check("to_next_wb_data", wb_data, 32'h77);
        check("to_next_wb_valid", {31'b0, wb_valid}, 32'd1);
        $display("txn timeout done req_cycles=%0d", req_cycles);

        // Ack on the same cycle the limit is reached wins over timeout
        present(1'b1, 5'd10, 9'd3, 32'h300, 32'h0);
        tick();
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check("lim_ack_no_to", {31'b0, timeout_err}, 32'd0);
        check("lim_ack_wb_we", {31'b0, wb_reg_write}, 32'd1);
        check("lim_ack_data", wb_data, 32'h12345678);
        $display("txn ack at limit done");

        // Reset during WAIT, then stray ack
        present(1'b1, 5'd10, 9'd4, 32'h400, 32'h0);
        tick();
        present(1'b0, 5'd0, 9'd0, 32'h0, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait_req", {31'b0, mem_req}, 32'd0);
        check("rst_wait_wb_data", wb_data, 32'h0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("rst_stray_ack", {31'b0, wb_valid}, 32'd0);
        check("rst_stray_req", {31'b0, mem_req}, 32'd0);
        $display("txn reset in wait done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_unit.md
Name: mem_stage_unit

Overview:
Memory-stage consumer of the EX/MEM pipeline register. It accepts the latched opcode, destination register and ALU result, performs the data-memory load/store through a req/ack handshake, and drives registered MEM/WB fields. It stalls upstream stages while a memory access is outstanding.

Parameters:
LOAD_OP, 5'd10, opcode value decoded as load word
STORE_OP, 5'd11, opcode value decoded as store word
TIMEOUT, 16, max cycles in WAIT before the access is abandoned (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  EX/MEM holds a valid instruction
op_code  in  5  opcode from EX/MEM
rd  in  9  destination register field from EX/MEM
alu_result  in  32  ALU result; byte address for load/store
store_data  in  32  data to write for store
stall  out  1  upstream must hold EX/MEM contents (combinational)
mem_req  out  1  memory request, registered
mem_we  out  1  1 = write, 0 = read, registered
mem_addr  out  32  byte address, registered
mem_wdata  out  32  write data, registered
mem_rdata  in  32  read data, valid with mem_ack
mem_ack  in  1  single-cycle access completion
wb_valid  out  1  MEM/WB fields valid this cycle (one-cycle pulse per instruction)
wb_op_code  out  5  opcode forwarded
wb_rd  out  9  destination forwarded
wb_data  out  32  load data or ALU result
wb_reg_write  out  1  register-file write enable for WB
misalign_err  out  1  one-cycle pulse: misaligned load/store
timeout_err  out  1  one-cycle pulse: access abandoned

Behaviour:
- States: IDLE, WAIT. Reset: state IDLE; every registered output 0 (mem_req, mem_we, mem_addr, mem_wdata, wb_*, errors); wait counter 0.
- stall = (IDLE & in_valid & is_mem & aligned) | (WAIT & ~mem_ack). is_mem = op_code==LOAD_OP or STORE_OP.
- IDLE, in_valid=0: wb_valid=0 next cycle.
- IDLE, in_valid, non-mem op: next edge wb_valid=1, wb_op_code/wb_rd copied, wb_data=alu_result, wb_reg_write=1. Latency 1 cycle. Back-to-back non-mem ops every cycle.
- IDLE, in_valid, mem op, alu_result[1:0]!=0: no request; next edge wb_valid=1, wb_reg_write=0, wb_data=alu_result, misalign_err=1 for one cycle; stay IDLE.
- IDLE, in_valid, aligned mem op: next edge state=WAIT, mem_req=1, mem_we=(op==STORE_OP), mem_addr=alu_result, mem_wdata=store_data; op_code and rd captured internally; counter cleared.
- WAIT: mem_req and address/data held stable. Counter increments each cycle without ack.
- WAIT & mem_ack: next edge mem_req=0, state=IDLE, wb_valid=1; load: wb_data=mem_rdata, wb_reg_write=1; store: wb_data=captured address, wb_reg_write=0. Minimum load/store latency 2 cycles from accept to wb_valid.
- WAIT, counter reaches TIMEOUT-1 with no ack: next edge mem_req=0, state=IDLE, wb_valid=1, wb_reg_write=0, timeout_err=1 one cycle. Ack in the same cycle as the limit takes priority (normal completion).
- mem_ack while IDLE: ignored, no WB effect.
- Instruction presented during WAIT is not accepted; it is taken in the IDLE cycle after completion (stall low on the ack cycle so upstream advances at that edge).
- wb_valid, misalign_err, timeout_err are single-cycle pulses; wb_op_code/wb_rd/wb_data hold last value when wb_valid=0.
- rst during WAIT: next edge all outputs 0, state IDLE; ack arriving after reset ignored.

Test Plan:
- Non-mem op 5'd3, rd=9'd7, alu_result=32'h1234 -> next cycle wb_valid=1, wb_data=32'h1234, wb_reg_write=1, stall never asserted.
- Load op 10, alu_result=32'h100, mem_ack 3 cycles after mem_req with mem_rdata=32'hDEADBEEF -> mem_addr=32'h100, mem_we=0, stall high until ack, wb_data=32'hDEADBEEF, wb_reg_write=1.
- Store op 11, alu_result=32'h40, store_data=32'hCAFE, immediate ack -> mem_we=1, mem_wdata=32'hCAFE, wb_valid=1 with wb_reg_write=0, wb_valid 2 cycles after accept.
- Load at alu_result=32'h102 -> no mem_req, misalign_err pulse, wb_valid=1, wb_reg_write=0.
- Load with no ack -> mem_req high exactly TIMEOUT cycles, then timeout_err pulse, wb_reg_write=0, state IDLE; next op accepted normally.
- rst asserted 2 cycles into WAIT, then ack pulse -> mem_req=0 after reset edge, no wb_valid from the stray ack.
